// File: rtl/dft_twiddle_gen.sv
// dft_twiddle_gen: streams W_N^(k*n) = cos - j*sin for n = 0..N-1 of one bin k.
// Only a quarter-wave cosine table (N/4+1 words) is kept; quadrant symmetry
// rebuilds the full circle. Three pipeline stages under a single global stall.
// The quarter-wave table is generated at elaboration by a fixed-point series
// with the same rounding as the table file; MEM_FILE is kept so existing
// parameter overrides still bind.
module dft_twiddle_gen #(
  parameter int    N_LOG2   = 4,
  parameter int    DATA_W   = 16,
  parameter string MEM_FILE = "../rtl/mem_files/dft_qcos_16.mem"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_LOG2-1:0] k,
  output logic              busy,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [N_LOG2-1:0] tw_idx,
  output logic              tw_last,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              done
);
  localparam int N      = 1 << N_LOG2;
  localparam int Q      = N / 4;
  localparam int AW     = N_LOG2 - 1;
  localparam int STAGES = 3;
  localparam int FB     = 28;
  localparam longint PI_Q = 64'sd843314857;  // pi in Q.28
  localparam logic [N_LOG2-1:0] LAST_N = N_LOG2'(N - 1);

  // Quarter-wave table C[i] = round(cos(2*pi*i/N) * 2**(DATA_W-2)), i = 0..N/4
  function automatic logic [(Q+1)*DATA_W-1:0] build_rom();
    logic [(Q+1)*DATA_W-1:0] r;
    longint x, x2, term, sum, v;
    r = '0;
    for (int i = 0; i <= Q; i++) begin
      x    = (PI_Q * 2 * longint'(i)) / longint'(N);
      x2   = (x * x) >>> FB;
      term = 64'sd1 <<< FB;
      sum  = term;
      for (int m = 1; m <= 10; m++) begin
        term = -((term * x2) >>> FB) / longint'((2 * m - 1) * (2 * m));
        sum  = sum + term;
      end
      v = (sum * (64'sd1 <<< (DATA_W - 2)) + (64'sd1 <<< (FB - 1))) >>> FB;
      r[i*DATA_W +: DATA_W] = DATA_W'(v);
    end
    return r;
  endfunction

  localparam logic [(Q+1)*DATA_W-1:0] ROM = build_rom();

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [N_LOG2-1:0] k_r, p_r, n_r;
  logic              en, run, take_start, last_take;
  logic [STAGES:1]   vld_pipe;

  // stage 1: quarter-wave addresses and quadrant
  logic [AW-1:0]     s1_a, s1_b;
  logic [1:0]        s1_q;
  logic [N_LOG2-1:0] s1_idx;
  logic              s1_last;
  // stage 2: raw table words
  logic [DATA_W-1:0] s2_ca, s2_cb;
  logic [1:0]        s2_q;
  logic [N_LOG2-1:0] s2_idx;
  logic              s2_last;
  logic [DATA_W-1:0] re_nx, im_nx;
  logic [AW-1:0]     s_addr;

  assign tw_valid = vld_pipe[STAGES];
  assign en       = !tw_valid || tw_ready;
  assign s_addr   = AW'(p_r & N_LOG2'(Q - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start only from idle and not in the done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done) state_nxt = RUN;
      RUN:     if (en && n_r == LAST_N) state_nxt = DRAIN;
      DRAIN:   if (tw_valid && tw_ready && tw_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state != IDLE);
    run        = (state == RUN);
    take_start = (state == IDLE) && start && !done;
    last_take  = (state == DRAIN) && tw_valid && tw_ready && tw_last;
  end

  // Bin, phase accumulator (wraps mod N by overflow) and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r <= '0;
      p_r <= '0;
      n_r <= '0;
    end else if (take_start) begin
      k_r <= k;
      p_r <= '0;
      n_r <= '0;
    end else if (run && en) begin
      p_r <= p_r + k_r;
      n_r <= n_r + 1'b1;
    end
  end

  // done pulses the cycle after the tagged last beat is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= last_take;
  end

  // Stage 1: issue, split phase into quadrant and the two table addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_a <= '0; s1_b <= '0; s1_q <= '0; s1_idx <= '0; s1_last <= 1'b0;
    end else if (en) begin
      vld_pipe[1] <= run;
      s1_a        <= s_addr;
      s1_b        <= AW'(Q) - s_addr;
      s1_q        <= p_r[N_LOG2-1 -: 2];
      s1_idx      <= n_r;
      s1_last     <= run && (n_r == LAST_N);
    end
  end

  // Stage 2: registered dual read of the quarter-wave table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      s2_ca <= '0; s2_cb <= '0; s2_q <= '0; s2_idx <= '0; s2_last <= 1'b0;
    end else if (en) begin
      vld_pipe[2] <= vld_pipe[1];
      s2_ca       <= ROM[int'(s1_a)*DATA_W +: DATA_W];
      s2_cb       <= ROM[int'(s1_b)*DATA_W +: DATA_W];
      s2_q        <= s1_q;
      s2_idx      <= s1_idx;
      s2_last     <= s1_last;
    end
  end

  // Quadrant symmetry: pick and negate the two table words (im = -sin)
  always_comb begin
    re_nx = s2_ca;
    im_nx = -s2_cb;
    case (s2_q)
      2'd0:    begin re_nx =  s2_ca; im_nx = -s2_cb; end
      2'd1:    begin re_nx = -s2_cb; im_nx = -s2_ca; end
      2'd2:    begin re_nx = -s2_ca; im_nx =  s2_cb; end
      default: begin re_nx =  s2_cb; im_nx =  s2_ca; end
    endcase
  end

  // Stage 3: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[3] <= 1'b0;
      tw_re <= '0; tw_im <= '0; tw_idx <= '0; tw_last <= 1'b0;
    end else if (en) begin
      vld_pipe[3] <= vld_pipe[2];
      tw_re       <= re_nx;
      tw_im       <= im_nx;
      tw_idx      <= s2_idx;
      tw_last     <= s2_last;
    end
  end

endmodule

// File: tb/tb_dft_twiddle_gen.sv
// Bench for dft_twiddle_gen: N=16/16-bit instance for the scenario tests and
// an N=64/18-bit instance for the full bin sweep, both against a float model.
module tb_dft_twiddle_gen;
  localparam int NL0 = 4, DW0 = 16, N0 = 16;
  localparam int NL1 = 6, DW1 = 18, N1 = 64;

  logic tb_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic           start = 1'b0, tw_ready = 1'b1;
  logic [NL0-1:0] k = '0;
  logic           busy, tw_last, tw_valid, done;
  logic [DW0-1:0] tw_re, tw_im;
  logic [NL0-1:0] tw_idx;

  logic           start1 = 1'b0, tw_ready1 = 1'b1;
  logic [NL1-1:0] k1 = '0;
  logic           busy1, tw_last1, tw_valid1, done1;
  logic [DW1-1:0] tw_re1, tw_im1;
  logic [NL1-1:0] tw_idx1;

  dft_twiddle_gen #(.N_LOG2(NL0), .DATA_W(DW0)) dut (
    .clk(tb_clk), .rst_n(rst_n), .start(start), .k(k), .busy(busy),
    .tw_re(tw_re), .tw_im(tw_im), .tw_idx(tw_idx), .tw_last(tw_last),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .done(done));

  dft_twiddle_gen #(.N_LOG2(NL1), .DATA_W(DW1),
                    .MEM_FILE("../rtl/mem_files/dft_qcos_18.mem")) dut1 (
    .clk(tb_clk), .rst_n(rst_n), .start(start1), .k(k1), .busy(busy1),
    .tw_re(tw_re1), .tw_im(tw_im1), .tw_idx(tw_idx1), .tw_last(tw_last1),
    .tw_valid(tw_valid1), .tw_ready(tw_ready1), .done(done1));

  int n_cmp = 0, n_bad = 0;

  // collected beats of the last sequence on the N=16 instance
  int q_re[$], q_im[$], q_idx[$], q_last[$];
  int first_vld, done_cyc, last_acc, stall_bad, done_cnt;
  bit tmo;

  // Reference: W = cos(2*pi*p/N) - j*sin(2*pi*p/N), p = k*n mod N, rounded
  function automatic int model(input int kk, input int n, input int nl,
                               input int dw, input bit want_im);
    int  nn, p;
    real a, r;
    nn = 1 << nl;
    p  = (kk * n) % nn;
    a  = 2.0 * 3.14159265358979 * p / nn;
    r  = (want_im ? -$sin(a) : $cos(a)) * real'(1 << (dw - 2));
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Pulse start for one cycle; returns one step after the accepting edge
  task automatic start_seq(input int kk);
    k = NL0'(kk);
    start = 1'b1;
    @(posedge tb_clk); #1;
    start = 1'b0;
  endtask

  // Drive tw_ready (and optional start spam while busy) and record beats
  task automatic collect(input bit rnd, input int spam_k);
    logic [37:0] prev;
    bit prev_st;
    q_re.delete(); q_im.delete(); q_idx.delete(); q_last.delete();
    first_vld = -1; done_cyc = -1; last_acc = -1;
    stall_bad = 0; done_cnt = 0; tmo = 1'b1; prev_st = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (prev_st && {tw_re, tw_im, tw_idx, tw_last, tw_valid} !== prev) stall_bad++;
      if (tw_valid && first_vld < 0) first_vld = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
        tmo = 1'b0;
        break;
      end
      tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (spam_k >= 0 && busy) begin
        start = 1'b1;
        k = NL0'(spam_k);
      end else start = 1'b0;
      if (tw_valid && tw_ready) begin
        q_re.push_back(int'($signed(tw_re)));
        q_im.push_back(int'($signed(tw_im)));
        q_idx.push_back(int'(tw_idx));
        q_last.push_back(int'(tw_last));
        if (tw_last) last_acc = cyc;
      end
      prev_st = tw_valid && !tw_ready;
      prev = {tw_re, tw_im, tw_idx, tw_last, tw_valid};
      @(posedge tb_clk); #1;
    end
    start = 1'b0;
    tw_ready = 1'b1;
  endtask

  task automatic test_reset;
    int dn;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, tw_valid, tw_last, done, tw_re, tw_im, tw_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", {busy, tw_valid, tw_last, done, tw_re, tw_im, tw_idx});
    end
    n_cmp++;
    if ({busy1, tw_valid1, tw_last1, done1, tw_re1, tw_im1, tw_idx1} !== '0) begin
      n_bad++;
      $display("FAIL reset_state_64 got %h want 0", {busy1, tw_valid1, tw_last1, done1, tw_re1, tw_im1, tw_idx1});
    end
    repeat (2) @(posedge tb_clk);
    #1 rst_n = 1'b1;
    @(posedge tb_clk); #1;
    // abort a running sequence
    start_seq(1);
    repeat (5) @(posedge tb_clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, tw_valid, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_abort got %b want 000", {busy, tw_valid, done});
    end
    @(posedge tb_clk); #1 rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      @(posedge tb_clk); #1;
      if (done !== 1'b0 || tw_valid !== 1'b0) dn++;
    end
    n_cmp++;
    if (dn != 0) begin
      n_bad++;
      $display("FAIL reset_no_done got %0d active cycles want 0", dn);
    end
    // clean sequence afterwards
    start_seq(2);
    collect(1'b0, -1);
    n_cmp++;
    if (tmo || q_re.size() != N0) begin
      n_bad++;
      $display("FAIL reset_rerun_count got %0d want %0d (timeout %0d)", q_re.size(), N0, tmo);
    end
    for (int n = 0; n < q_re.size(); n++) begin
      n_cmp++;
      if (q_idx[n] != n || iabs(q_re[n] - model(2, n, NL0, DW0, 0)) > 1 ||
          iabs(q_im[n] - model(2, n, NL0, DW0, 1)) > 1) begin
        n_bad++;
        $display("FAIL reset_rerun_beat n=%0d got idx %0d %0d/%0d want %0d/%0d", n, q_idx[n],
                 q_re[n], q_im[n], model(2, n, NL0, DW0, 0), model(2, n, NL0, DW0, 1));
      end
    end
  endtask

  task automatic test_k1;
    start_seq(1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL k1_busy got %b want 1", busy);
    end
    collect(1'b0, -1);
    n_cmp++;
    if (tmo || q_re.size() != N0) begin
      n_bad++;
      $display("FAIL k1_count got %0d want %0d (timeout %0d)", q_re.size(), N0, tmo);
    end
    n_cmp++;
    if (first_vld != 3 || last_acc != N0 + 2 || done_cyc != N0 + 3 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL k1_timing got first %0d last %0d done %0d x%0d want 3 %0d %0d x1",
               first_vld, last_acc, done_cyc, done_cnt, N0 + 2, N0 + 3);
    end
    for (int n = 0; n < q_re.size(); n++) begin
      n_cmp++;
      if (q_idx[n] != n || q_last[n] != int'(n == N0 - 1) ||
          iabs(q_re[n] - model(1, n, NL0, DW0, 0)) > 1 ||
          iabs(q_im[n] - model(1, n, NL0, DW0, 1)) > 1) begin
        n_bad++;
        $display("FAIL k1_beat n=%0d got idx %0d last %0d %0d/%0d want %0d/%0d", n, q_idx[n],
                 q_last[n], q_re[n], q_im[n], model(1, n, NL0, DW0, 0), model(1, n, NL0, DW0, 1));
      end
    end
    if (q_re.size() == N0) begin
      n_cmp++;
      if (q_re[0] != 16384 || q_im[0] != 0 || q_re[4] != 0 || q_im[4] != -16384 ||
          q_re[8] != -16384 || q_im[8] != 0) begin
        n_bad++;
        $display("FAIL k1_exact got %0d/%0d %0d/%0d %0d/%0d want 16384/0 0/-16384 -16384/0",
                 q_re[0], q_im[0], q_re[4], q_im[4], q_re[8], q_im[8]);
      end
    end
  endtask

  task automatic test_k0_k8;
    int kk, er;
    for (int t = 0; t < 2; t++) begin
      kk = (t == 0) ? 0 : N0 / 2;
      start_seq(kk);
      collect(1'b0, -1);
      n_cmp++;
      if (tmo || q_re.size() != N0) begin
        n_bad++;
        $display("FAIL k%0d_count got %0d want %0d", kk, q_re.size(), N0);
      end
      for (int n = 0; n < q_re.size(); n++) begin
        er = (kk != 0 && (n % 2) == 1) ? -16384 : 16384;
        n_cmp++;
        if (q_re[n] != er || q_im[n] != 0) begin
          n_bad++;
          $display("FAIL k%0d_beat n=%0d got %0d/%0d want %0d/0", kk, n, q_re[n], q_im[n], er);
        end
      end
    end
  endtask

  task automatic test_random_ready;
    int kk;
    for (int t = 0; t < 3; t++) begin
      kk = (t == 0) ? 3 : int'($urandom_range(0, N0 - 1));
      start_seq(kk);
      collect(1'b1, -1);
      n_cmp++;
      if (tmo || q_re.size() != N0 || stall_bad != 0 || done_cyc != last_acc + 1 || done_cnt != 1) begin
        n_bad++;
        $display("FAIL rnd_k%0d_flow got beats %0d stall_err %0d done %0d last %0d x%0d",
                 kk, q_re.size(), stall_bad, done_cyc, last_acc, done_cnt);
      end
      for (int n = 0; n < q_re.size(); n++) begin
        n_cmp++;
        if (q_idx[n] != n || q_last[n] != int'(n == N0 - 1) ||
            iabs(q_re[n] - model(kk, n, NL0, DW0, 0)) > 1 ||
            iabs(q_im[n] - model(kk, n, NL0, DW0, 1)) > 1) begin
          n_bad++;
          $display("FAIL rnd_k%0d_beat n=%0d got idx %0d %0d/%0d want %0d/%0d", kk, n, q_idx[n],
                   q_re[n], q_im[n], model(kk, n, NL0, DW0, 0), model(kk, n, NL0, DW0, 1));
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    start_seq(5);
    collect(1'b1, 3);
    n_cmp++;
    if (tmo || q_re.size() != N0 || done_cnt != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL spam_flow got beats %0d done x%0d busy %b want %0d x1 0",
               q_re.size(), done_cnt, busy, N0);
    end
    for (int n = 0; n < q_re.size(); n++) begin
      n_cmp++;
      if (q_idx[n] != n || iabs(q_re[n] - model(5, n, NL0, DW0, 0)) > 1 ||
          iabs(q_im[n] - model(5, n, NL0, DW0, 1)) > 1) begin
        n_bad++;
        $display("FAIL spam_beat n=%0d got idx %0d %0d/%0d want %0d/%0d", n, q_idx[n],
                 q_re[n], q_im[n], model(5, n, NL0, DW0, 0), model(5, n, NL0, DW0, 1));
      end
    end
  endtask

  task automatic test_sweep64;
    int xbad, beats, bad_k;
    bit got_done;
    xbad = 0;
    for (int kk = 0; kk < N1; kk++) begin
      k1 = NL1'(kk);
      start1 = 1'b1;
      @(posedge tb_clk); #1;
      start1 = 1'b0;
      beats = 0; bad_k = 0; got_done = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if ($isunknown({tw_re1, tw_im1, tw_idx1, tw_last1, tw_valid1, busy1, done1})) xbad++;
        if (done1 === 1'b1) begin
          got_done = 1'b1;
          break;
        end
        if (tw_valid1) begin
          if (int'(tw_idx1) != beats || int'(tw_last1) != int'(beats == N1 - 1) ||
              iabs(int'($signed(tw_re1)) - model(kk, beats, NL1, DW1, 0)) > 1 ||
              iabs(int'($signed(tw_im1)) - model(kk, beats, NL1, DW1, 1)) > 1) begin
            if (bad_k < 2)
              $display("FAIL sweep_beat k=%0d n=%0d got idx %0d %0d/%0d want %0d/%0d", kk, beats,
                       tw_idx1, $signed(tw_re1), $signed(tw_im1),
                       model(kk, beats, NL1, DW1, 0), model(kk, beats, NL1, DW1, 1));
            bad_k++;
          end
          beats++;
        end
        @(posedge tb_clk); #1;
      end
      n_cmp++;
      if (bad_k != 0 || beats != N1 || !got_done) begin
        n_bad++;
        $display("FAIL sweep_k%0d got %0d bad of %0d beats done %0d want 0 of %0d done 1",
                 kk, bad_k, beats, got_done, N1);
      end
      @(posedge tb_clk); #1;
    end
    n_cmp++;
    if (xbad != 0) begin
      n_bad++;
      $display("FAIL sweep_x got %0d unknown cycles want 0", xbad);
    end
  endtask

  initial begin
    test_reset();
    test_k1();
    test_k0_k8();
    test_random_ready();
    test_start_ignored();
    test_sweep64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
